// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared state, opcode and datapath-select encodings for the RV32 multicycle control
package rv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC_R = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_TRAP   = 4'd9
   } state_t;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;

   localparam logic [1:0] ALU_ADD    = 2'b00;
   localparam logic [1:0] ALU_SUB    = 2'b01;
   localparam logic [1:0] ALU_FUNCT  = 2'b10;

   function automatic logic is_mem_op(input logic [6:0] opc);
      return (opc == OPC_LOAD) || (opc == OPC_STORE);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts memory wait cycles and flags a timeout
// MEM_TIMEOUT = 0 disables the timeout; the counter then saturates harmlessly.
module mem_wait_timer #(
   parameter int WAIT_CNT_W  = 8,
   parameter int MEM_TIMEOUT = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic waiting,
   output logic timeout
);

   localparam logic [WAIT_CNT_W-1:0] LIMIT = WAIT_CNT_W'(MEM_TIMEOUT);

   logic [WAIT_CNT_W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (waiting && (r_count != '1)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign timeout = (MEM_TIMEOUT != 0) && (r_count == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore control FSM sequencing the multicycle RV32 datapath
// Optional illegal-opcode trap state and illegal_instr port under MCCTRL_ILLEGAL_TRAP_EN.
module multicycle_control
   import rv_ctrl_pkg::*;
#(
   parameter int WAIT_CNT_W  = 8,
   parameter int MEM_TIMEOUT = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       addr_sel,
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_src,
   output logic       reg_write,
   output logic       wb_sel,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       mem_err,
`ifdef MCCTRL_ILLEGAL_TRAP_EN
   output logic       illegal_instr,
`endif
   output logic [3:0] state_o
);

   state_t     r_state;
   state_t     w_next;
   logic       r_hold;
   logic       w_timeout;
   logic       w_timeout_hit;
   logic       w_clear;
   logic       w_mem_req;
   logic       w_mem_we;
   logic       w_addr_sel;
   logic       w_ir_write;
   logic       w_pc_write;
   logic       w_pc_src;
   logic       w_reg_write;
   logic       w_wb_sel;
   logic [1:0] w_alu_src_a;
   logic [1:0] w_alu_src_b;
   logic [1:0] w_alu_op;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
   logic       w_illegal;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_FETCH;
         r_hold  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_hold  <= w_timeout_hit;
      end
   end

   // r_hold keeps mem_req low for the one cycle after a timeout so the retried fetch is a fresh request.
   always_comb begin
      w_next        = r_state;
      w_mem_req     = 1'b0;
      w_mem_we      = 1'b0;
      w_addr_sel    = 1'b0;
      w_ir_write    = 1'b0;
      w_pc_write    = 1'b0;
      w_pc_src      = 1'b0;
      w_reg_write   = 1'b0;
      w_wb_sel      = 1'b0;
      w_alu_src_a   = SRCA_PC;
      w_alu_src_b   = SRCB_RS2;
      w_alu_op      = ALU_ADD;
      w_timeout_hit = 1'b0;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
      w_illegal     = 1'b0;
`endif
      case (r_state)
         S_FETCH: begin
            w_mem_req   = !r_hold;
            w_alu_src_a = SRCA_PC;
            w_alu_src_b = SRCB_FOUR;
            w_alu_op    = ALU_ADD;
            if (w_mem_req && mem_ready) begin
               w_ir_write = 1'b1;
               w_pc_write = 1'b1;
               w_next     = S_DECODE;
            end
         end
         S_DECODE: begin
            w_alu_src_a = SRCA_OLDPC;
            w_alu_src_b = SRCB_IMM;
            if (is_mem_op(opcode))          w_next = S_MEMADR;
            else if (opcode == OPC_RTYPE)   w_next = S_EXEC_R;
            else if (opcode == OPC_BRANCH)  w_next = S_BRANCH;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
            else                            w_next = S_TRAP;
`else
            else                            w_next = S_FETCH;
`endif
         end
         S_MEMADR: begin
            w_alu_src_a = SRCA_RS1;
            w_alu_src_b = SRCB_IMM;
            w_next      = (opcode == OPC_LOAD) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            w_mem_req  = 1'b1;
            w_addr_sel = 1'b1;
            if (mem_ready) w_next = S_MEMWB;
         end
         S_MEMWB: begin
            w_reg_write = 1'b1;
            w_wb_sel    = 1'b1;
            w_next      = S_FETCH;
         end
         S_MEMWR: begin
            w_mem_req  = 1'b1;
            w_mem_we   = 1'b1;
            w_addr_sel = 1'b1;
            if (mem_ready) w_next = S_FETCH;
         end
         S_EXEC_R: begin
            w_alu_src_a = SRCA_RS1;
            w_alu_src_b = SRCB_RS2;
            w_alu_op    = ALU_FUNCT;
            w_next      = S_ALUWB;
         end
         S_ALUWB: begin
            w_reg_write = 1'b1;
            w_next      = S_FETCH;
         end
         S_BRANCH: begin
            w_alu_src_a = SRCA_RS1;
            w_alu_src_b = SRCB_RS2;
            w_alu_op    = ALU_SUB;
            w_pc_src    = 1'b1;
            w_pc_write  = zero;
            w_next      = S_FETCH;
         end
`ifdef MCCTRL_ILLEGAL_TRAP_EN
         S_TRAP: begin
            w_alu_src_a = SRCA_PC;
            w_illegal   = 1'b1;
         end
`endif
         default: w_next = S_FETCH;
      endcase
      // A completing mem_ready always beats the timeout.
      if (w_mem_req && !mem_ready && w_timeout) begin
         w_timeout_hit = 1'b1;
         w_next        = S_FETCH;
      end
   end

   assign w_clear = (w_next != r_state) || w_timeout_hit;

   mem_wait_timer #(
      .WAIT_CNT_W  (WAIT_CNT_W),
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_mem_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (w_clear),
      .waiting (w_mem_req && !mem_ready),
      .timeout (w_timeout)
   );

   assign mem_req   = rst_n & w_mem_req;
   assign mem_we    = rst_n & w_mem_we;
   assign addr_sel  = rst_n & w_addr_sel;
   assign ir_write  = rst_n & w_ir_write;
   assign pc_write  = rst_n & w_pc_write;
   assign pc_src    = rst_n & w_pc_src;
   assign reg_write = rst_n & w_reg_write;
   assign wb_sel    = rst_n & w_wb_sel;
   assign alu_src_a = rst_n ? w_alu_src_a : 2'b00;
   assign alu_src_b = rst_n ? w_alu_src_b : 2'b00;
   assign alu_op    = rst_n ? w_alu_op    : 2'b00;
   assign mem_err   = rst_n & w_timeout_hit;
   assign state_o   = r_state;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
   assign illegal_instr = rst_n & w_illegal;
`endif

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style control FSM that sequences the multicycle RV32 datapath: instruction fetch, decode, address/ALU execute, memory access and writeback.
- Drives the mux selects, write enables and memory handshake around the shared ALU, register file and immediate generator.
- Supported opcodes: load 0000011, store 0100011, branch 1100011, R-type 0110011.
- Sits beside the datapath top and consumes only the opcode field and the ALU zero flag.

Parameters:
- WAIT_CNT_W, 8, width of the memory-wait counter.
- MEM_TIMEOUT, 0, maximum mem_ready wait cycles; 0 = wait forever. Must be < 2^WAIT_CNT_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  7  instruction[6:0] from the instruction register.
- zero  in  1  ALU zero flag, combinational.
- mem_ready  in  1  memory completed the current request this cycle.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  write qualifier, valid with mem_req.
- addr_sel  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load IR and OLDPC.
- pc_write  out  1  PC load enable.
- pc_src  out  1  PC source: 0 = ALU result, 1 = ALUOut.
- reg_write  out  1  register file write enable.
- wb_sel  out  1  writeback source: 0 = ALUOut, 1 = memory data register.
- alu_src_a  out  2  00 = PC, 01 = OLDPC, 10 = rs1.
- alu_src_b  out  2  00 = rs2, 01 = constant 4, 10 = immediate.
- alu_op  out  2  00 = ADD, 01 = SUB, 10 = decode by funct.
- mem_err  out  1  one-cycle pulse on memory timeout.
- state_o  out  4  current state, for debug.

Behaviour:
- Reset: rst_n low forces state to FETCH, clears the wait counter and drives every output to 0, including mem_req. The same applies mid-operation; an aborted memory access is never completed.
- Outputs decode combinationally from state, plus mem_ready for the completion strobes. Unlisted outputs are 0.
- Encodings: FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXEC_R = 6, ALUWB = 7, BRANCH = 8, TRAP = 9.
- FETCH:
  - Drives mem_req = 1, addr_sel = 0, alu_src_a = 00, alu_src_b = 01, alu_op = ADD.
  - In the cycle mem_ready = 1: ir_write = 1, pc_write = 1, pc_src = 0, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Drives alu_src_a = 01, alu_src_b = 10, ADD, so ALUOut holds the branch target.
  - Next state: load/store go to MEMADR, R-type to EXEC_R, branch to BRANCH.
  - Any other opcode: see Optional Feature.
- MEMADR: alu_src_a = 10, alu_src_b = 10, ADD. Load goes to MEMRD, store to MEMWR.
- MEMRD: mem_req = 1, addr_sel = 1. On mem_ready go to MEMWB.
- MEMWB: reg_write = 1, wb_sel = 1, then go to FETCH.
- MEMWR: mem_req = 1, mem_we = 1, addr_sel = 1. On mem_ready go to FETCH.
- EXEC_R: alu_src_a = 10, alu_src_b = 00, alu_op = 10, then go to ALUWB.
- ALUWB: reg_write = 1, wb_sel = 0, then go to FETCH.
- BRANCH: alu_src_a = 10, alu_src_b = 00, SUB, pc_src = 1, pc_write = zero, then go to FETCH.
- Instruction latency with mem_ready returned in the same cycle:
  - load: 5 cycles.
  - store: 4 cycles.
  - R-type: 4 cycles.
  - branch: 3 cycles.
- Wait counter:
  - Counts cycles spent in a mem_req state with mem_ready = 0.
  - Clears on every state change.
  - When MEM_TIMEOUT != 0 and the count reaches MEM_TIMEOUT, mem_err pulses for 1 cycle and mem_req drops in the next cycle.
  - After a timeout in FETCH: retry FETCH; PC is unchanged.
  - After a timeout in MEMRD or MEMWR: abort to FETCH with no register write.
- mem_ready outside a mem_req state is ignored.
- mem_ready and the timeout in the same cycle: mem_ready wins and no mem_err is raised.

Optional Feature:
- Macro: MCCTRL_ILLEGAL_TRAP_EN.
- Defined: an unsupported opcode in DECODE moves to TRAP. TRAP holds all outputs at 0 except a 1-bit output port illegal_instr = 1, and stays there until reset.
- Undefined: an unsupported opcode returns to FETCH as a NOP, and the illegal_instr port does not exist.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - the state enum;
  - opcode constants OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_RTYPE;
  - the alu_src_a, alu_src_b and alu_op encodings.
- The immediate generator reuses the opcode constants from rv_ctrl_pkg.
- One sub-module, mem_wait_timer, holds the wait counter and timeout compare: inputs clear and waiting, output timeout.

Test Plan:
- Reset, then lw (opcode 0000011) with mem_ready = 1 every cycle -> states 0, 1, 2, 3, 4, 0; exactly one ir_write and one reg_write with wb_sel = 1.
- sw with mem_ready delayed 3 cycles in MEMWR -> mem_req and mem_we held for 4 cycles, no reg_write, return to FETCH.
- beq with zero = 1, then zero = 0 -> pc_write = 1 with pc_src = 1 in BRANCH only in the first case.
- MEM_TIMEOUT = 4, mem_ready held at 0 in FETCH -> mem_err pulses after 4 waiting cycles, state stays FETCH, no pc_write.
- Reset asserted mid-MEMRD -> all outputs 0 immediately, state_o = 0 after release.
- Opcode 1111111 -> with MCCTRL_ILLEGAL_TRAP_EN: state 9 and illegal_instr = 1 held until reset; without it: state back to 0 after DECODE.
